led_bank_arbiter: RTL and testbench



---
 rtl/led_pkg.sv | 16 +
 rtl/led_rr_pick.sv | 36 +++
 rtl/led_bank_arbiter.sv | 133 +++++++++++++
 tb/tb_led_bank_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED bank arbiter.
package led_pkg;

  typedef enum logic {IDLE, SHOW} led_state_t;

  localparam int NUM_REQ_DEF  = 4;
  localparam int NUM_LEDS_DEF = 8;
  localparam int DWELL_DEF    = 1000000;
  localparam int PWM_BITS_DEF = 4;

  // Index width that never collapses to zero bits for tiny ranges.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker: first requester from last+1 upward,
// wrapping, with the previous owner itself considered last.
module led_rr_pick
  import led_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [NUM_REQ-1:0] onehot_o
);

  logic [IDX_W-1:0] cand;
  logic             hit;

  // Scan candidates in priority order and keep the first one that is high.
  always_comb begin
    hit      = 1'b0;
    cand     = '0;
    idx_o    = '0;
    onehot_o = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
      if (!hit && req_i[cand]) begin
        hit           = 1'b1;
        idx_o         = cand;
        onehot_o[cand] = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of a shared LED bank with per-owner pattern and PWM
// brightness latched at grant time.
// Build option: define LED_ACTIVE_LOW_EN to invert the led output for
// boards that sink LED current (led idles all-ones).
module led_bank_arbiter
  import led_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int NUM_LEDS = NUM_LEDS_DEF,
  parameter int DWELL    = DWELL_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_LEDS-1:0]  pattern,
  input  logic [NUM_REQ*PWM_BITS-1:0]  level,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic [NUM_LEDS-1:0]          led
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(DWELL);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_REQ - 1);

  led_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d;
  logic [PWM_BITS-1:0] lvl_q, lvl_d;
  logic [CNT_W-1:0]    dwell_q, dwell_d;
  logic [PWM_BITS-1:0] pwm_q;

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [NUM_LEDS-1:0] pat_sel;
  logic [PWM_BITS-1:0] lvl_sel;
  logic                rearb;
  logic                pwm_on;
  logic [NUM_LEDS-1:0] led_act;

  led_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx),
    .onehot_o (pick_oh)
  );

  // Select the candidate's pattern and brightness slices for latching.
  always_comb begin
    pat_sel = '0;
    lvl_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pat_sel = pattern[i*NUM_LEDS +: NUM_LEDS];
        lvl_sel = level[i*PWM_BITS +: PWM_BITS];
      end
    end
  end

  // Next-state logic: IDLE arbitrates every cycle; SHOW re-arbitrates on
  // dwell expiry or owner release (both at once count as one pick).
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    pat_d   = pat_q;
    lvl_d   = lvl_q;
    dwell_d = dwell_q;
    rearb   = 1'b0;
    case (state_q)
      IDLE: rearb = 1'b1;
      SHOW: begin
        dwell_d = dwell_q + 1'b1;
        rearb   = (dwell_q == DWELL_LAST) || !(|(req & grant_q));
      end
      default: rearb = 1'b1;
    endcase
    if (rearb) begin
      dwell_d = '0;
      if (pick_found) begin
        state_d = SHOW;
        grant_d = pick_oh;
        last_d  = pick_idx;
        pat_d   = pat_sel;
        lvl_d   = lvl_sel;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  // State, latches and counters; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      pat_q   <= '0;
      lvl_q   <= '0;
      dwell_q <= '0;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      pat_q   <= pat_d;
      lvl_q   <= lvl_d;
      dwell_q <= dwell_d;
      pwm_q   <= pwm_q + 1'b1;
    end
  end

  // Output decode from registers only; all-ones brightness is forced fully on.
  always_comb begin
    pwm_on  = (lvl_q == '1) || (pwm_q < lvl_q);
    led_act = busy ? (pat_q & {NUM_LEDS{pwm_on}}) : '0;
`ifdef LED_ACTIVE_LOW_EN
    led     = ~led_act;
`else
    led     = led_act;
`endif
  end

  assign grant = grant_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter (NUM_REQ=4, NUM_LEDS=8, DWELL=8, PWM_BITS=2).
module tb_led_bank_arbiter;

  localparam int NR = 4;
  localparam int NL = 8;
  localparam int DW = 8;
  localparam int PB = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] pattern = '0;
  logic [7:0]  level = '0;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  led;

  led_bank_arbiter #(
    .NUM_REQ(NR), .NUM_LEDS(NL), .DWELL(DW), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pattern(pattern), .level(level),
    .grant(grant), .busy(busy), .led(led)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] pat;
    logic [7:0]  lvl;
    logic [3:0]  g;
    logic [7:0]  l;
  } vec_t;
  vec_t tbl[$];

  // Maps an active-high LED value to what the pin carries in this build.
  function automatic logic [7:0] drv(input logic [7:0] v);
`ifdef LED_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [7:0] l);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(|g));
    chk({tag, ".led"}, 32'(led), 32'(drv(l)));
  endtask

  task automatic add(input logic [3:0] r, input logic [31:0] p, input logic [7:0] lv,
                     input logic [3:0] g, input logic [7:0] l, input int n = 1);
    vec_t v;
    v.req = r; v.pat = p; v.lvl = lv; v.g = g; v.l = l;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  localparam logic [31:0] P4 = 32'h08040201;
  localparam logic [7:0]  LF = 8'hFF;

  initial begin
    int on_cnt;
    int first_on;
    int second_on;
    logic [7:0] lv;

    // Single requester: pattern change after grant appears only at re-grant (8 cycles).
    add(4'b0001, 32'h000000A5, 8'h03, 4'b0001, 8'hA5);
    add(4'b0001, 32'h0000003C, 8'h03, 4'b0001, 8'hA5, 7);
    add(4'b0001, 32'h0000003C, 8'h03, 4'b0001, 8'h3C, 4);
    add(4'b0000, 32'h0000003C, 8'h03, 4'b0000, 8'h00);
    // All four requesting: rotation starting after last owner 0, 8 cycles each.
    add(4'b1111, P4, LF, 4'b0010, 8'h02, 8);
    add(4'b1111, P4, LF, 4'b0100, 8'h04, 8);
    add(4'b1111, P4, LF, 4'b1000, 8'h08, 8);
    add(4'b1111, P4, LF, 4'b0001, 8'h01, 8);
    add(4'b1111, P4, LF, 4'b0010, 8'h02, 2);
    // Two requesters; owner 0 releases 3 cycles in, owner 1 gets a full fresh dwell.
    add(4'b0011, P4, LF, 4'b0010, 8'h02, 6);
    add(4'b0011, P4, LF, 4'b0001, 8'h01, 3);
    add(4'b0010, P4, LF, 4'b0010, 8'h02, 1);
    add(4'b0011, P4, LF, 4'b0010, 8'h02, 7);
    add(4'b0011, P4, LF, 4'b0001, 8'h01, 2);
    add(4'b0000, P4, LF, 4'b0000, 8'h00, 1);

    // Reset: outputs must clear asynchronously, then stay idle with req=0.
    #3 rst_n = 1'b0;
    #1 check_out("in_reset", 4'b0000, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_out("idle", 4'b0000, 8'h00);
    end

    foreach (tbl[i]) begin
      req     = tbl[i].req;
      pattern = tbl[i].pat;
      level   = tbl[i].lvl;
      step();
      check_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].l);
    end

    // PWM duty with level 1: on exactly when the 2-bit counter is 0.
    req = 4'b0001; pattern = 32'h000000FF; level = 8'h01;
    on_cnt = 0; first_on = -1; second_on = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("pwm1.grant", 32'(grant), 32'(4'b0001));
      lv = drv(led);
      chk("pwm1.shape", 32'(lv == 8'h00 || lv == 8'hFF), 32'd1);
      if (lv == 8'hFF) begin
        on_cnt++;
        if (first_on < 0) first_on = i;
        else if (second_on < 0) second_on = i;
      end
    end
    chk("pwm1.on_count", 32'(on_cnt), 32'd2);
    chk("pwm1.period", 32'(second_on - first_on), 32'd4);

    // Level 0 after a fresh grant: bank owned but dark.
    req = 4'b0000;
    step();
    check_out("pwm_gap", 4'b0000, 8'h00);
    req = 4'b0001; level = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      check_out("pwm0", 4'b0001, 8'h00);
    end

    // Reset mid-grant to req2; first grant afterwards searches from req0.
    pattern = P4; level = LF;
    req = 4'b0000;
    step();
    check_out("pre_rst_idle", 4'b0000, 8'h00);
    req = 4'b0100;
    step();
    check_out("own2_a", 4'b0100, 8'h04);
    step(); step();
    #2 rst_n = 1'b0;
    #1 check_out("async_rst_a", 4'b0000, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0110;
    step();
    check_out("post_rst_a", 4'b0010, 8'h02);

    // Second pulse: with req=1100 a stale pointer of 2 would pick 3 instead of 2.
    req = 4'b0100;
    step();
    check_out("own2_b", 4'b0100, 8'h04);
    step();
    #2 rst_n = 1'b0;
    #1 check_out("async_rst_b", 4'b0000, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; req = 4'b1100;
    step();
    check_out("post_rst_b", 4'b0100, 8'h04);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
